alinhador_serial: RTL and testbench

//  Front end of the float adder datapath: unpacks two IEEE-754 single operands, orders them by

---
 rtl/alinhador_serial.sv | 146 ++++++++++++++
 tb/tb_alinhador_serial.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alinhador_serial.sv
// rtl/alinhador_serial.sv - exponent alignment front end for the float adder
// Orders two IEEE-754 singles by exponent and serially right-shifts the smaller fraction with G/R/S.
module alinhador_serial #(
   parameter int SHIFT_STEP = 1,
   parameter int SAT_LIMIT  = 27
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  exp_out,
   output logic [26:0] fract_big,
   output logic [26:0] fract_small,
   output logic        sign_big,
   output logic        sign_small,
   output logic        swap,
   output logic        special
);

   typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

   localparam logic [7:0] STEP8 = 8'(SHIFT_STEP);

   state_t      state, state_next;
   logic [31:0] a_reg, b_reg, a_next, b_next;
   logic [7:0]  rem, rem_next, exp_next;
   logic [26:0] fb_next, fs_next;
   logic        sb_next, ss_next, swap_next, special_next;

   logic [7:0]  ea_raw, eb_raw, ea, eb, e_big, e_small, diff, step_k;
   logic [26:0] fa, fb, f_big, f_small, shifted;
   logic        b_wins, special_c, sticky;

   // Denormals use effective exponent 1 with a zero hidden bit.
   assign ea_raw    = a_reg[30:23];
   assign eb_raw    = b_reg[30:23];
   assign ea        = (ea_raw == 8'd0) ? 8'd1 : ea_raw;
   assign eb        = (eb_raw == 8'd0) ? 8'd1 : eb_raw;
   assign fa        = {|ea_raw, a_reg[22:0], 3'b000};
   assign fb        = {|eb_raw, b_reg[22:0], 3'b000};
   assign b_wins    = eb > ea;
   assign e_big     = b_wins ? eb : ea;
   assign e_small   = b_wins ? ea : eb;
   assign f_big     = b_wins ? fb : fa;
   assign f_small   = b_wins ? fa : fb;
   assign diff      = e_big - e_small;
   assign special_c = (&ea_raw) | (&eb_raw);

   assign step_k  = (rem < STEP8) ? rem : STEP8;
   assign shifted = fract_small >> step_k;

   // Everything leaving the window (plus the old bit0 sticky) folds into the new bit0.
   always_comb begin
      sticky = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         if (8'(i) <= step_k) sticky = sticky | fract_small[i];
      end
   end

   always_comb begin
      state_next   = state;
      a_next       = a_reg;
      b_next       = b_reg;
      rem_next     = rem;
      exp_next     = exp_out;
      fb_next      = fract_big;
      fs_next      = fract_small;
      sb_next      = sign_big;
      ss_next      = sign_small;
      swap_next    = swap;
      special_next = special;
      case (state)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               state_next = COMPARE;
            end
         end
         COMPARE: begin
            swap_next    = b_wins;
            exp_next     = special_c ? 8'hFF : e_big;
            fb_next      = f_big;
            fs_next      = f_small;
            sb_next      = b_wins ? b_reg[31] : a_reg[31];
            ss_next      = b_wins ? a_reg[31] : b_reg[31];
            special_next = special_c;
            rem_next     = diff;
            if (special_c || diff == 8'd0) begin
               state_next = DONE;
            end else if (int'(diff) >= SAT_LIMIT) begin
               fs_next    = {26'd0, |f_small};
               state_next = DONE;
            end else begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            fs_next  = {shifted[26:1], shifted[0] | sticky};
            rem_next = rem - step_k;
            if (rem == step_k) state_next = DONE;
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         rem         <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         exp_out     <= '0;
         fract_big   <= '0;
         fract_small <= '0;
         sign_big    <= 1'b0;
         sign_small  <= 1'b0;
         swap        <= 1'b0;
         special     <= 1'b0;
      end else begin
         state       <= state_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         rem         <= rem_next;
         in_ready    <= (state_next == IDLE);
         out_valid   <= (state_next == DONE);
         exp_out     <= exp_next;
         fract_big   <= fb_next;
         fract_small <= fs_next;
         sign_big    <= sb_next;
         sign_small  <= ss_next;
         swap        <= swap_next;
         special     <= special_next;
      end
   end

endmodule

// File: tb/tb_alinhador_serial.sv
// tb/tb_alinhador_serial.sv - scoreboard bench for alinhador_serial
// Driver pushes model results into a queue; monitor pops and compares on the output handshake.
module tb_alinhador_serial;

   localparam int STEP = 1;
   localparam int SAT  = 27;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [7:0]  exp_out;
   logic [26:0] fract_big, fract_small;
   logic        sign_big, sign_small, swap, special;

   alinhador_serial #(.SHIFT_STEP(STEP), .SAT_LIMIT(SAT)) dut (
      .clock(clock), .reset_n(reset_n), .a(a), .b(b), .in_valid(in_valid),
      .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .exp_out(exp_out), .fract_big(fract_big), .fract_small(fract_small),
      .sign_big(sign_big), .sign_small(sign_small), .swap(swap), .special(special)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  e;
      logic [26:0] fb, fs;
      logic        sb, ss, sw, sp;
      int          lat;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0;
   bit   hold_ready = 1'b0;
   bit   seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Alignment as arithmetic: shift by the whole difference, OR every lost bit into bit 0.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv);
      exp_t   r;
      int     ea, eb, eea, eeb, ebig, d;
      longint fa, fb, fbig, fsmall, fsm;
      bit     bw;
      ea  = int'(av[30:23]);
      eb  = int'(bv[30:23]);
      eea = (ea == 0) ? 1 : ea;
      eeb = (eb == 0) ? 1 : eb;
      fa  = ((ea != 0) ? 64'h800000 : 64'h0) + longint'(av[22:0]);
      fb  = ((eb != 0) ? 64'h800000 : 64'h0) + longint'(bv[22:0]);
      fa  = fa * 8;
      fb  = fb * 8;
      bw  = eeb > eea;
      ebig   = bw ? eeb : eea;
      d      = bw ? eeb - eea : eea - eeb;
      fbig   = bw ? fb : fa;
      fsmall = bw ? fa : fb;
      r.sw = bw;
      r.sb = bw ? bv[31] : av[31];
      r.ss = bw ? av[31] : bv[31];
      r.sp = (ea == 255) || (eb == 255);
      r.e  = r.sp ? 8'hFF : 8'(ebig);
      if (r.sp || d == 0) fsm = fsmall;
      else if (d >= SAT) fsm = (fsmall != 0) ? 64'd1 : 64'd0;
      else begin
         fsm = fsmall >> d;
         if ((fsmall & ((longint'(1) << d) - 1)) != 0) fsm = fsm | 64'd1;
      end
      r.fb  = 27'(fbig);
      r.fs  = 27'(fsm);
      r.lat = (r.sp || d == 0 || d >= SAT) ? 1 : 1 + (d + STEP - 1) / STEP;
      r.acc = 0;
      return r;
   endfunction

   task automatic send(input logic [31:0] av, input logic [31:0] bv, input bit push);
      int   n = 0;
      exp_t e;
      @(negedge clock);
      while (!in_ready && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL in_ready_timeout actual=0 required=1");
         return;
      end
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      if (push) begin
         e = model(av, bv);
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 3000) begin
         @(negedge clock);
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout actual=%0d required=0", q.size());
      end
      @(negedge clock);
   endtask

   // Monitor: compares every cycle the result is presented, pops on handshake.
   initial begin
      exp_t cur;
      forever begin
         @(negedge clock);
         if (reset_n && out_valid) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out actual=1 required=0");
            end else begin
               cur = q[0];
               if (!seen) begin
                  check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
                  seen = 1'b1;
               end
               check("exp_out", 32'(exp_out), 32'(cur.e));
               check("fract_big", 32'(fract_big), 32'(cur.fb));
               check("fract_small", 32'(fract_small), 32'(cur.fs));
               check("sign_big", 32'(sign_big), 32'(cur.sb));
               check("sign_small", 32'(sign_small), 32'(cur.ss));
               check("swap", 32'(swap), 32'(cur.sw));
               check("special", 32'(special), 32'(cur.sp));
               check("in_ready_busy", 32'(in_ready), 32'd0);
            end
         end
         out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 1) == 1);
         if (reset_n && out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            seen = 1'b0;
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_exp_out"}, 32'(exp_out), 32'd0);
      check({tag, "_fract_big"}, 32'(fract_big), 32'd0);
      check({tag, "_fract_small"}, 32'(fract_small), 32'd0);
      check({tag, "_flags"}, 32'({sign_big, sign_small, swap, special}), 32'd0);
   endtask

   logic [31:0] dir_a[6] = '{32'h40000000, 32'h3F800001, 32'h4E800000, 32'h00800000, 32'h7F800000, 32'hC0400000};
   logic [31:0] dir_b[6] = '{32'h3F800000, 32'h41000000, 32'h3F800000, 32'h00000001, 32'h3F800000, 32'h3FFFFFFF};

   initial begin
      logic [31:0] ra, rb;
      int          sel, e1, e2;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_idle_zero("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) send(dir_a[i], dir_b[i], 1'b1);
      drain();

      // Consumer stall: result must stay put while out_ready is low.
      hold_ready = 1'b1;
      send(32'h40000000, 32'h3F800000, 1'b1);
      repeat (8) @(negedge clock);
      hold_ready = 1'b0;
      drain();

      // Reset while shifting a d=23 operation.
      send(32'h4B000000, 32'h3F800000, 1'b0);
      repeat (5) @(negedge clock);
      check("mid_shift_out_valid", 32'(out_valid), 32'd0);
      check("mid_shift_in_ready", 32'(in_ready), 32'd0);
      reset_n = 1'b0;
      @(negedge clock);
      check_idle_zero("mid_reset");
      reset_n = 1'b1;
      repeat (40) @(negedge clock);

      for (int i = 0; i < 150; i++) begin
         sel = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom;
         if (sel == 1) ra[30:23] = 8'hFF;
         else if (sel == 2) begin
            ra[30:23] = 8'($urandom_range(0, 1));
            rb[30:23] = 8'($urandom_range(0, 1));
         end else if (sel >= 3) begin
            e1 = $urandom_range(1, 254);
            e2 = e1 - $urandom_range(0, 30);
            if (e2 < 0) e2 = 0;
            ra[30:23] = 8'(e1);
            rb[30:23] = 8'(e2);
            if ($urandom_range(0, 1) == 1) {ra, rb} = {rb, ra};
         end
         send(ra, rb, 1'b1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
